// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM encoding,
// parity-mode constants and small helper functions.
package sipo_rx_pkg;

    // Frame sequencing states, kept as plain encoded constants so the
    // encoding stays stable for code that compares raw state values.
    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DATA   = 2'd1;
    localparam state_t ST_PARITY = 2'd2;
    localparam state_t ST_STOP   = 2'd3;

    // Parity modes: the value the XOR of data plus parity bit must equal.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Bit counter width for a given word width (never narrower than 1).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // True when the received parity bit does not match the expected mode.
    function automatic logic parity_bad(input logic data_xor,
                                        input logic par_bit,
                                        input logic mode);
        return (data_xor ^ par_bit) != mode;
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register. Bits enter at the MSB and move
// toward the LSB, so after WIDTH shifts the first bit sits in q[0].
module sipo_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // Clear has priority over shift; otherwise hold.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial frame receiver controller. Sequences start, data, optional parity
// and stop bits on an external bit-rate strobe, steers data bits into a SIPO
// and presents good words on a single-entry valid/ready buffer with sticky
// error flags.
module sipo_rx_ctrl
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             data_in,
    input  logic             dout_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic           PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
    localparam logic           HAS_PAR  = (PARITY_EN != 0);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             par_bad;
    logic [WIDTH-1:0] sipo;

    logic start_seen;
    logic sr_clr;
    logic sr_shift;
    logic stop_strobe;
    logic fe_evt;
    logic pe_evt;
    logic good_word;
    logic load_word;
    logic ov_evt;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk      (clk),
        .reset    (reset),
        .clr      (sr_clr),
        .shift_en (sr_shift),
        .sin      (data_in),
        .q        (sipo)
    );

    assign start_seen = bit_en && (state == ST_IDLE) && !data_in;

    // Next-state and SIPO control; only a bit strobe advances the frame.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        sr_clr    = 1'b0;
        sr_shift  = 1'b0;
        if (bit_en) begin
            case (state)
                ST_IDLE: begin
                    if (!data_in) begin
                        state_nxt = ST_DATA;
                        sr_clr    = 1'b1;
                    end
                end
                ST_DATA: begin
                    sr_shift = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = HAS_PAR ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: state_nxt = ST_STOP;
                ST_STOP:   state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Data-bit counter: cleared by the start bit, stepped per data bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start_seen) begin
            cnt <= '0;
        end else if (bit_en && state == ST_DATA) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Parity verdict, captured on the parity strobe and reset per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bad <= 1'b0;
        end else if (start_seen) begin
            par_bad <= 1'b0;
        end else if (bit_en && state == ST_PARITY) begin
            par_bad <= parity_bad(^sipo, data_in, PAR_MODE);
        end
    end

    // Stop-bit outcome: a bad stop bit outranks a parity error, and a good
    // word is dropped only when the buffer is full and not draining now.
    assign stop_strobe = bit_en && (state == ST_STOP);
    assign fe_evt      = stop_strobe && !data_in;
    assign pe_evt      = stop_strobe && data_in && par_bad;
    assign good_word   = stop_strobe && data_in && !par_bad;
    assign load_word   = good_word && (!dout_valid || dout_ready);
    assign ov_evt      = good_word && dout_valid && !dout_ready;

    assign busy = (state != ST_IDLE);

    // Single-entry output buffer with valid/ready handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (load_word) begin
            dout       <= sipo;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (fe_evt) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (pe_evt) begin
                parity_err <= 1'b1;
            end else if (err_clr) begin
                parity_err <= 1'b0;
            end
            if (ov_evt) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
